// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory-port arbiter.
// Holds the arbiter state encoding and the datapath width.
package pipeline_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wait_watchdog.sv
// Counts wait cycles on the shared memory port.
// Flags one cycle as the count reaches TIMEOUT, then saturates.
module wait_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (busy && cnt_q != SAT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the wait cycle whose edge makes the count saturate.
  assign expired = busy && !clear && (cnt_q == SAT - 1'b1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM; MEM always wins.
// Drives PC/IF-ID write enables and the downstream pipeline hold.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic              hazard_stall,
  output logic              port_req,
  output logic              port_we,
  output logic [WORD_W-1:0] port_addr,
  output logic [WORD_W-1:0] port_wdata,
  input  logic              port_ready,
  input  logic [WORD_W-1:0] port_rdata,
  output logic [WORD_W-1:0] if_instr,
  output logic              if_valid,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              pipe_hold,
  output logic              bus_err
);

  arb_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              served_q, served_d;
  logic              bus_err_q;
  logic              advance;
  logic              expired;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    if_valid_d = 1'b0;
    mem_done_d = 1'b0;
    served_d   = served_q;
    unique case (state_q)
      IDLE: begin
        if ((mem_read || mem_write) && !served_q) begin
          state_d = DATA;
          addr_d  = mem_addr;
          we_d    = mem_write;
          wdata_d = mem_wdata;
        end else if (if_req) begin
          state_d = FETCH;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      DATA: begin
        if (port_ready) begin
          if (!we_q)
            rdata_d = port_rdata;
          mem_done_d = 1'b1;
          served_d   = 1'b1;
          if (if_req) begin
            state_d = FETCH;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FETCH: begin
        if (port_ready) begin
          instr_d    = port_rdata;
          if_valid_d = 1'b1;
          // Pipeline advances here, so the MEM op in flight is retired.
          served_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      instr_q    <= '0;
      rdata_q    <= '0;
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      served_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      if_valid_q <= if_valid_d;
      mem_done_q <= mem_done_d;
      served_q   <= served_d;
      bus_err_q  <= bus_err_q | expired;
    end
  end

  wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .busy   ((state_q != IDLE) && !port_ready),
    .clear  (state_d != state_q),
    .expired(expired)
  );

  assign advance     = (state_q == FETCH) && port_ready;
  assign PCWrite     = advance && !hazard_stall;
  assign IF_ID_Write = advance && !hazard_stall;
  assign pipe_hold   = !advance;

  assign port_req   = (state_q != IDLE);
  assign port_we    = we_q;
  assign port_addr  = addr_q;
  assign port_wdata = wdata_q;
  assign if_instr   = instr_q;
  assign if_valid   = if_valid_q;
  assign mem_rdata  = rdata_q;
  assign mem_done   = mem_done_q;
  assign bus_err    = bus_err_q;

endmodule
